event_pacer: RTL and testbench



---
 rtl/event_pacer_if.sv | 30 +++
 rtl/event_pacer.sv | 120 ++++++++++++
 tb/tb_event_pacer.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/event_pacer_if.sv
// Connection bundle between an event source, the event pacer and the downstream
// toggle synchronizer: request/clear inputs plus the paced pulse and status outputs.
interface event_pacer_if #(
    parameter int CNT_W = 4
);
    logic             event_in;
    logic             clear_ovf;
    logic             event_out;
    logic [CNT_W-1:0] pending;
    logic             busy;
    logic             overflow;

    modport master (
        output event_in,
        output clear_ovf,
        input  event_out,
        input  pending,
        input  busy,
        input  overflow
    );

    modport slave (
        input  event_in,
        input  clear_ovf,
        output event_out,
        output pending,
        output busy,
        output overflow
    );
endinterface

// File: rtl/event_pacer.sv
// Buffers bursty single-cycle event requests in a saturating counter and re-emits them
// as single-cycle pulses spaced GAP_CYCLES+1 apart so a toggle synchronizer never loses one.
module event_pacer #(
    parameter int GAP_CYCLES = 4,
    parameter int CNT_W      = 4
) (
    input  logic         clk,
    input  logic         rst,
    event_pacer_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic [7:0]       GAP_LOAD = 8'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] MAX_PEND = '1;

    state_t           r_state;
    state_t           w_nextState;
    logic [7:0]       r_gapCnt;
    logic [7:0]       w_gapCntNext;
    logic [CNT_W-1:0] r_pending;
    logic [CNT_W-1:0] w_pendingNext;
    logic             r_eventOut;
    logic             r_overflow;
    logic             w_overflowNext;
    logic             w_haveWork;
    logic             w_launchSlot;
    logic             w_launch;
    logic             w_drop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // A pulse may start from IDLE or from the final GAP cycle, fed by either a stored or a fresh event.
    always_comb begin
        w_haveWork   = (r_pending != '0) || bus.event_in;
        w_launchSlot = (r_state == IDLE) || ((r_state == GAP) && (r_gapCnt == 8'd0));
        w_launch     = w_launchSlot && w_haveWork;
        w_nextState  = r_state;
        case (r_state)
            IDLE: begin
                if (w_launch) begin
                    w_nextState = PULSE;
                end
            end
            PULSE: begin
                w_nextState = GAP;
            end
            GAP: begin
                if (w_launch) begin
                    w_nextState = PULSE;
                end else if (r_gapCnt == 8'd0) begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    always_comb begin
        w_gapCntNext   = 8'd0;
        w_pendingNext  = r_pending;
        w_drop         = 1'b0;
        w_overflowNext = r_overflow;

        if (r_state == PULSE) begin
            w_gapCntNext = GAP_LOAD;
        end else if ((r_state == GAP) && (r_gapCnt != 8'd0)) begin
            w_gapCntNext = r_gapCnt - 8'd1;
        end

        // On a launch an arriving event simply replaces the one consumed, so a full counter stays full.
        if (w_launch) begin
            if ((r_pending != '0) && !bus.event_in) begin
                w_pendingNext = r_pending - CNT_W'(1);
            end
        end else if (bus.event_in) begin
            if (r_pending == MAX_PEND) begin
                w_drop = 1'b1;
            end else begin
                w_pendingNext = r_pending + CNT_W'(1);
            end
        end

        if (w_drop) begin
            w_overflowNext = 1'b1;
        end else if (bus.clear_ovf) begin
            w_overflowNext = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gapCnt   <= 8'd0;
            r_pending  <= '0;
            r_eventOut <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_gapCnt   <= w_gapCntNext;
            r_pending  <= w_pendingNext;
            r_eventOut <= (w_nextState == PULSE);
            r_overflow <= w_overflowNext;
        end
    end

    assign bus.event_out = r_eventOut;
    assign bus.pending   = r_pending;
    assign bus.busy      = (r_state != IDLE) || (r_pending != '0);
    assign bus.overflow  = r_overflow;
endmodule

// File: tb/tb_event_pacer.sv
// Self-checking bench for event_pacer: fixed vector table for pulse timing, directed
// corner sequences and a randomized run checked against a timestamp-based reference model.
module tb_event_pacer;
    localparam int GAP   = 4;
    localparam int CNT_W = 4;
    localparam int MAX   = 15;

    logic clk;
    logic rst;

    event_pacer_if #(.CNT_W(CNT_W)) bus ();

    event_pacer #(
        .GAP_CYCLES(GAP),
        .CNT_W     (CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic ev;
        logic clr;
        logic expOut;
        int   expPending;
        logic expBusy;
        logic expOvf;
    } vec_t;

    vec_t vecs[$];

    int nCompared;
    int nMismatched;

    // Reference model: a pulse may start once GAP cycles have passed since the previous one.
    int     mPending;
    longint mCyc;
    longint mLastPulse;
    bit     mOvf;
    int     mInjected;
    int     mDropped;
    int     dutPulses;
    int     maxPendSeen;

    task automatic checkValue(input string name, input longint act, input longint exp);
        nCompared++;
        if (act != exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void addVec(input logic ev, input logic clr, input logic expOut,
                                   input int expPending, input logic expBusy, input logic expOvf);
        vec_t v;
        v.ev         = ev;
        v.clr        = clr;
        v.expOut     = expOut;
        v.expPending = expPending;
        v.expBusy    = expBusy;
        v.expOvf     = expOvf;
        vecs.push_back(v);
    endfunction

    function automatic void modelReset();
        mPending    = 0;
        mCyc        = 0;
        mLastPulse  = -1000;
        mOvf        = 1'b0;
        mInjected   = 0;
        mDropped    = 0;
        dutPulses   = 0;
        maxPendSeen = 0;
    endfunction

    function automatic bit modelSlotOpen();
        return (mCyc - mLastPulse) >= GAP;
    endfunction

    function automatic void modelStep(input bit ev, input bit clr);
        int avail;
        bit setOvf;
        avail  = mPending + int'(ev);
        setOvf = 1'b0;
        if (modelSlotOpen() && (avail > 0)) begin
            mLastPulse = mCyc + 1;
            mPending   = avail - 1;
        end else if (avail > MAX) begin
            mPending = MAX;
            mDropped++;
            setOvf = 1'b1;
        end else begin
            mPending = avail;
        end
        if (setOvf) begin
            mOvf = 1'b1;
        end else if (clr) begin
            mOvf = 1'b0;
        end
        if (ev) begin
            mInjected++;
        end
        mCyc++;
    endfunction

    task automatic checkOutput();
        bit expOut;
        bit expBusy;
        expOut  = (mCyc == mLastPulse);
        expBusy = ((mCyc >= mLastPulse) && ((mCyc - mLastPulse) <= GAP)) || (mPending != 0);
        checkValue("model_event_out", bus.event_out, expOut);
        checkValue("model_pending", bus.pending, mPending);
        checkValue("model_busy", bus.busy, expBusy);
        checkValue("model_overflow", bus.overflow, mOvf);
        if (bus.event_out) begin
            dutPulses++;
        end
        if (int'(bus.pending) > maxPendSeen) begin
            maxPendSeen = int'(bus.pending);
        end
    endtask

    task automatic applyStimulus(input bit ev, input bit clr);
        bus.event_in  = ev;
        bus.clear_ovf = clr;
        modelStep(ev, clr);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task automatic resetDut();
        rst           = 1'b1;
        bus.event_in  = 1'b0;
        bus.clear_ovf = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        modelReset();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int  boundaryHits;
        bit  done;
        bit  slot;
        int  burstPct;

        nCompared     = 0;
        nMismatched   = 0;
        rst           = 1'b1;
        bus.event_in  = 1'b0;
        bus.clear_ovf = 1'b0;
        modelReset();

        // Single request, then a three-event burst: pulse spacing and pending counts.
        addVec(1, 0, 0, 0, 0, 0);
        addVec(0, 0, 1, 0, 1, 0);
        addVec(0, 0, 0, 0, 1, 0);
        addVec(0, 0, 0, 0, 1, 0);
        addVec(0, 0, 0, 0, 1, 0);
        addVec(0, 0, 0, 0, 1, 0);
        addVec(0, 0, 0, 0, 0, 0);
        addVec(1, 0, 0, 0, 0, 0);
        addVec(1, 0, 1, 0, 1, 0);
        addVec(1, 0, 0, 1, 1, 0);
        addVec(0, 0, 0, 2, 1, 0);
        addVec(0, 0, 0, 2, 1, 0);
        addVec(0, 0, 0, 2, 1, 0);
        addVec(0, 0, 1, 1, 1, 0);
        addVec(0, 0, 0, 1, 1, 0);
        addVec(0, 0, 0, 1, 1, 0);
        addVec(0, 0, 0, 1, 1, 0);
        addVec(0, 0, 0, 1, 1, 0);
        addVec(0, 0, 1, 0, 1, 0);
        addVec(0, 0, 0, 0, 1, 0);
        addVec(0, 0, 0, 0, 1, 0);
        addVec(0, 0, 0, 0, 1, 0);
        addVec(0, 0, 0, 0, 1, 0);
        addVec(0, 0, 0, 0, 0, 0);

        resetDut();
        checkValue("reset_event_out", bus.event_out, 0);
        checkValue("reset_pending", bus.pending, 0);
        checkValue("reset_busy", bus.busy, 0);
        checkValue("reset_overflow", bus.overflow, 0);
        for (int i = 0; i < vecs.size(); i++) begin
            checkValue($sformatf("vec%0d_event_out", i), bus.event_out, vecs[i].expOut);
            checkValue($sformatf("vec%0d_pending", i), bus.pending, vecs[i].expPending);
            checkValue($sformatf("vec%0d_busy", i), bus.busy, vecs[i].expBusy);
            checkValue($sformatf("vec%0d_overflow", i), bus.overflow, vecs[i].expOvf);
            bus.event_in  = vecs[i].ev;
            bus.clear_ovf = vecs[i].clr;
            @(posedge clk);
            #1;
        end

        // Saturation: 40 back-to-back requests, then drain and reconcile pulse count.
        resetDut();
        checkOutput();
        for (int i = 0; i < 40; i++) applyStimulus(1'b1, 1'b0);
        for (int i = 0; i < 90; i++) applyStimulus(1'b0, 1'b0);
        checkValue("sat_max_pending", maxPendSeen, MAX);
        checkValue("sat_overflow_sticky", bus.overflow, 1);
        checkValue("sat_pulse_count", dutPulses, 40 - mDropped);

        // Clearing overflow without a drop, then clear colliding with a drop.
        applyStimulus(1'b0, 1'b1);
        checkValue("clear_ovf_no_drop", bus.overflow, 0);
        done = 1'b0;
        for (int i = 0; i < 80 && !done; i++) begin
            slot = modelSlotOpen();
            if (mOvf && !slot && (mPending == MAX)) begin
                applyStimulus(1'b1, 1'b1);
                checkValue("ovf_set_beats_clear", bus.overflow, 1);
                done = 1'b1;
            end else begin
                applyStimulus(1'b1, 1'b0);
            end
        end
        checkValue("ovf_collision_reached", done, 1);

        // Full counter meeting a launch with a new request: nothing dropped.
        resetDut();
        checkOutput();
        boundaryHits = 0;
        for (int i = 0; i < 40; i++) begin
            slot = modelSlotOpen();
            if (slot && (mPending == MAX)) begin
                applyStimulus(1'b1, 1'b0);
                checkValue("boundary_pending_held", bus.pending, MAX);
                checkValue("boundary_no_overflow", bus.overflow, 0);
                boundaryHits++;
            end else begin
                applyStimulus((mPending < MAX) || slot, 1'b0);
            end
        end
        checkValue("boundary_reached", boundaryHits > 0, 1);

        // Asynchronous reset in the middle of a gap with events queued.
        resetDut();
        checkOutput();
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0);
        checkValue("pre_reset_pending", bus.pending, 3);
        #2;
        rst = 1'b1;
        #1;
        checkValue("async_rst_event_out", bus.event_out, 0);
        checkValue("async_rst_pending", bus.pending, 0);
        checkValue("async_rst_busy", bus.busy, 0);
        checkValue("async_rst_overflow", bus.overflow, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        modelReset();
        checkOutput();
        applyStimulus(1'b1, 1'b0);
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0);
        checkValue("post_reset_pulses", dutPulses, 1);

        // Randomized traffic with bursty phases and occasional overflow clears.
        resetDut();
        checkOutput();
        for (int i = 0; i < 400; i++) begin
            burstPct = ((i / 50) % 2 == 0) ? 90 : 20;
            applyStimulus($urandom_range(0, 99) < burstPct, $urandom_range(0, 19) == 0);
        end
        for (int i = 0; i < 90; i++) applyStimulus(1'b0, 1'b0);
        checkValue("rand_pulse_count", dutPulses, mInjected - mDropped);
        checkValue("rand_drained_busy", bus.busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end
endmodule
